// File: rtl/accel_read_seq_if.sv
// Command/response bundle between the accelerometer read sequencer and the 16-bit SPI master.
// The sequencer owns start/tx_data; the SPI master returns rx_data and busy.
interface accel_read_seq_if;
    logic        spi_start;
    logic [15:0] spi_tx_data;
    logic [15:0] spi_rx_data;
    logic        spi_busy;

    modport master (output spi_start, output spi_tx_data, input spi_rx_data, input spi_busy);
    modport slave  (input spi_start, input spi_tx_data, output spi_rx_data, output spi_busy);
endinterface

// File: rtl/accel_read_seq.sv
// Configures an ADXL345-style accelerometer over SPI, then periodically burst-reads X/Y/Z.
// Define ACCEL_DEVID_CHECK_EN to read and verify DEVID (0xE5) before configuration.
module accel_read_seq #(
    parameter int         SAMPLE_PERIOD   = 100000,
    parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0] POWER_CTL_VAL   = 8'h08,
    parameter int         FRAME_GAP       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    accel_read_seq_if.master  spi,
    output logic [15:0]       accel_x,
    output logic [15:0]       accel_y,
    output logic [15:0]       accel_z,
    output logic              sample_valid,
    output logic              init_done,
    output logic              seq_error
);
    localparam int              TW        = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TW-1:0]   TIMER_MAX = TW'(SAMPLE_PERIOD - 1);
    localparam logic [15:0]     GAP_LAST  = (FRAME_GAP > 1) ? 16'(FRAME_GAP - 1) : 16'd0;

    typedef enum logic [2:0] {
        S_WAIT_IDLE, S_GAP, S_ISSUE, S_WAIT_RISE, S_WAIT_FALL, S_IDLE, S_DEVID_FAIL
    } state_t;

    typedef enum logic [1:0] {M_BOOT, M_DEVID, M_INIT, M_BURST} mode_t;

    state_t        state, state_d;
    mode_t         mode, mode_d;
    logic [2:0]    frame_idx, frame_d;
    logic [TW-1:0] timer;
    logic [15:0]   gap_cnt;
    logic [1:0]    rise_cnt;
    logic [15:0]   tx_reg;
    logic [7:0]    byte_buf [0:5];
    logic [7:0]    rx_byte;
    logic          unused_rx_hi;
    logic          load_tx, latch_byte, set_err, set_init, finish_burst, burst_start;

    assign rx_byte         = spi.spi_rx_data[7:0];
    assign unused_rx_hi    = ^spi.spi_rx_data[15:8];
    assign spi.spi_start   = (state == S_ISSUE);
    assign spi.spi_tx_data = tx_reg;

    // Frame word for a given phase and index: reads set bit15, MB is always 0.
    function automatic logic [15:0] frame_word(input mode_t m, input logic [2:0] idx);
        logic [15:0] w;
        w = 16'h0000;
        case (m)
            M_DEVID: w = 16'h8000;
            M_INIT:  w = (idx == 3'd0) ? {8'h31, DATA_FORMAT_VAL} : {8'h2D, POWER_CTL_VAL};
            M_BURST: w = {2'b10, 6'h32 + {3'b000, idx}, 8'h00};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d      = state;
        mode_d       = mode;
        frame_d      = frame_idx;
        load_tx      = 1'b0;
        latch_byte   = 1'b0;
        set_err      = 1'b0;
        set_init     = 1'b0;
        finish_burst = 1'b0;
        burst_start  = 1'b0;
        case (state)
            S_WAIT_IDLE: begin
                if (!spi.spi_busy) state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = S_ISSUE;
                    load_tx = 1'b1;
                    case (mode)
                        M_BOOT: begin
`ifdef ACCEL_DEVID_CHECK_EN
                            mode_d = M_DEVID;
`else
                            mode_d = M_INIT;
`endif
                            frame_d = 3'd0;
                        end
                        M_DEVID: begin
                            mode_d  = M_INIT;
                            frame_d = 3'd0;
                        end
                        M_INIT: begin
                            if (frame_idx == 3'd1) begin
                                state_d  = S_IDLE;
                                load_tx  = 1'b0;
                                set_init = 1'b1;
                            end else begin
                                frame_d = frame_idx + 3'd1;
                            end
                        end
                        default: begin
                            if (frame_idx == 3'd5) begin
                                state_d      = S_IDLE;
                                load_tx      = 1'b0;
                                finish_burst = 1'b1;
                            end else begin
                                frame_d = frame_idx + 3'd1;
                            end
                        end
                    endcase
                end
            end
            S_ISSUE: state_d = S_WAIT_RISE;
            S_WAIT_RISE: begin
                // A master that never acknowledges gets the same frame again.
                if (spi.spi_busy) begin
                    state_d = S_WAIT_FALL;
                end else if (rise_cnt == 2'd3) begin
                    state_d = S_ISSUE;
                    set_err = 1'b1;
                end
            end
            S_WAIT_FALL: begin
                if (!spi.spi_busy) begin
                    latch_byte = 1'b1;
                    state_d    = S_GAP;
`ifdef ACCEL_DEVID_CHECK_EN
                    if (mode == M_DEVID && rx_byte != 8'hE5) begin
                        state_d = S_DEVID_FAIL;
                        set_err = 1'b1;
                    end
`endif
                end
            end
            S_IDLE: begin
                if (init_done && en && timer == TIMER_MAX) begin
                    burst_start = 1'b1;
                    mode_d      = M_BURST;
                    frame_d     = 3'd0;
                    state_d     = S_ISSUE;
                    load_tx     = 1'b1;
                end
            end
            S_DEVID_FAIL: state_d = S_DEVID_FAIL;
            default:      state_d = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT_IDLE;
            mode      <= M_BOOT;
            frame_idx <= 3'd0;
        end else begin
            state     <= state_d;
            mode      <= mode_d;
            frame_idx <= frame_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg       <= 16'h0000;
            timer        <= '0;
            gap_cnt      <= 16'd0;
            rise_cnt     <= 2'd0;
            accel_x      <= 16'h0000;
            accel_y      <= 16'h0000;
            accel_z      <= 16'h0000;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            seq_error    <= 1'b0;
            for (int i = 0; i < 6; i++) byte_buf[i] <= 8'h00;
        end else begin
            gap_cnt  <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
            rise_cnt <= (state == S_WAIT_RISE) ? rise_cnt + 2'd1 : 2'd0;
            if (load_tx) tx_reg <= frame_word(mode_d, frame_d);
            // Saturating timer: an overrun never queues extra periods.
            if (burst_start) timer <= '0;
            else if (init_done && timer != TIMER_MAX) timer <= timer + TW'(1);
            if (latch_byte && frame_idx <= 3'd5) byte_buf[frame_idx] <= rx_byte;
            sample_valid <= finish_burst;
            if (finish_burst) begin
                accel_x <= {byte_buf[1], byte_buf[0]};
                accel_y <= {byte_buf[3], byte_buf[2]};
                accel_z <= {byte_buf[5], byte_buf[4]};
            end
            if (set_init) init_done <= 1'b1;
            if (set_err)  seq_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_accel_read_seq.sv
// Scoreboard bench for accel_read_seq: expected frames/samples are queued by the stimulus
// and popped by a monitor; a small SPI master model answers frames with a byte table.
module tb_accel_read_seq;
    localparam int W_VALID = 0, W_BSTART = 1, W_INIT = 2, W_STARTS = 3;
`ifdef ACCEL_DEVID_CHECK_EN
    localparam int          NINIT    = 3;
    localparam logic [15:0] FIRST_TX = 16'h8000;
`else
    localparam int          NINIT    = 2;
    localparam logic [15:0] FIRST_TX = 16'h310B;
`endif

    logic        clk, rst, en;
    logic [15:0] ax, ay, az;
    logic        sv, idn, serr;

    accel_read_seq_if spi();

    accel_read_seq #(
        .SAMPLE_PERIOD(500), .DATA_FORMAT_VAL(8'h0B), .POWER_CTL_VAL(8'h08), .FRAME_GAP(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .spi(spi),
        .accel_x(ax), .accel_y(ay), .accel_z(az),
        .sample_valid(sv), .init_done(idn), .seq_error(serr)
    );

    int          checks = 0, failures = 0, cyc = 0;
    logic [15:0] exp_tx[$];
    logic [47:0] exp_samp[$];
    int          bstart[$], vcyc[$], scyc[$];
    int          fall_cyc = -1000;
    logic        prev_busy = 1'b0;
    int          ft = 20, hold_until = 0, busy_left = 0;
    bit          respond = 1'b1, in_hold = 1'b0;
    logic        start_seen = 1'b0;
    logic [15:0] tx_seen = 16'h0, cur_tx = 16'h0;
    logic [7:0]  rbytes [6];
    logic [7:0]  devid = 8'hE5;
    int          n0, en_cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [7:0] respByte(input logic [15:0] tx);
        int a;
        a = int'(tx[13:8]);
        if (a == 0) return devid;
        if (a >= 'h32 && a <= 'h37) return rbytes[a - 'h32];
        return 8'h00;
    endfunction

    // SPI master model: busy rises the cycle after start is sampled, lasts ft cycles.
    initial forever begin
        @(negedge clk);
        start_seen = spi.spi_start;
        tx_seen    = spi.spi_tx_data;
    end

    initial begin
        spi.spi_busy    = 1'b0;
        spi.spi_rx_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (cyc < hold_until) begin
                spi.spi_busy = 1'b1;
                in_hold      = 1'b1;
                busy_left    = 0;
            end else if (in_hold) begin
                spi.spi_busy = 1'b0;
                in_hold      = 1'b0;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
                if (busy_left == 0) begin
                    spi.spi_busy    = 1'b0;
                    spi.spi_rx_data = {8'h00, respByte(cur_tx)};
                end
            end else if (start_seen && respond) begin
                spi.spi_busy = 1'b1;
                cur_tx       = tx_seen;
                busy_left    = ft - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input int n);
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        repeat (n) @(negedge clk);
    endtask

    task automatic waitUntil(input int which, input int target, input int limit, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            case (which)
                W_VALID:  ok = (vcyc.size() >= target);
                W_BSTART: ok = (bstart.size() >= target);
                W_INIT:   ok = (idn == 1'b1);
                default:  ok = (scyc.size() >= target);
            endcase
            if (ok) break;
            @(negedge clk);
            #1;
        end
        checks = checks + 1;
        if (!ok) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: not reached within %0d cycles, required count %0d", name, limit, target);
        end
    endtask

    task automatic pushBurst(input logic [47:0] s);
        for (int i = 0; i < 6; i++) exp_tx.push_back(16'hB200 + 16'(i) * 16'h0100);
        exp_samp.push_back(s);
    endtask

    task automatic setBytes(input logic [47:0] b);
        for (int i = 0; i < 6; i++) rbytes[i] = b[47 - 8*i -: 8];
    endtask

    // Monitor: pops the scoreboard whenever a start pulse or sample_valid appears.
    initial forever begin
        @(negedge clk);
        if (!spi.spi_busy && prev_busy) fall_cyc = cyc;
        prev_busy = spi.spi_busy;
        if (spi.spi_start) begin
            scyc.push_back(cyc);
            checkOutput("start_while_busy", 48'(spi.spi_busy), 48'd0);
            checkOutput("frame_gap", 48'(cyc - fall_cyc >= 8), 48'd1);
            if (exp_tx.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("[TB] FAIL unexpected_start: got tx %h, expected no start", spi.spi_tx_data);
            end else begin
                checkOutput("tx_data", 48'(spi.spi_tx_data), 48'(exp_tx.pop_front()));
            end
            if (spi.spi_tx_data == 16'hB200) bstart.push_back(cyc);
        end
        if (sv) begin
            vcyc.push_back(cyc);
            if (exp_samp.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("[TB] FAIL unexpected_sample_valid: got %h, expected no pulse", {ax, ay, az});
            end else begin
                checkOutput("sample_xyz", {ax, ay, az}, exp_samp.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        setBytes(48'h0);
`ifdef ACCEL_DEVID_CHECK_EN
        exp_tx.push_back(16'h8000);
`endif
        exp_tx.push_back(16'h310B);
        exp_tx.push_back(16'h2D08);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("rst_spi_start", 48'(spi.spi_start), 48'd0);
        checkOutput("rst_tx_data", 48'(spi.spi_tx_data), 48'd0);
        checkOutput("rst_xyz", {ax, ay, az}, 48'd0);
        checkOutput("rst_flags", 48'({sv, idn, serr}), 48'd0);

        applyStimulus(1'b0, 1'b0, 1);
        waitUntil(W_INIT, 1, 400, "init_done_rise");
        checkOutput("init_start_count", 48'(scyc.size()), 48'(NINIT));

        $display("[TB] burst 1: signed sample assembly");
        setBytes(48'h3412CDAB0080);
        pushBurst({16'h1234, 16'hABCD, 16'h8000});
        applyStimulus(1'b0, 1'b1, 1);
        waitUntil(W_VALID, 1, 1500, "burst1_valid");
        applyStimulus(1'b0, 1'b1, 50);
        checkOutput("hold_xyz", {ax, ay, az}, {16'h1234, 16'hABCD, 16'h8000});
        checkOutput("sv_low_between", 48'(sv), 48'd0);

        $display("[TB] burst 2: exact period");
        setBytes(48'h0100FFFF7F7F);
        pushBurst({16'h0001, 16'hFFFF, 16'h7F7F});
        waitUntil(W_VALID, 2, 1000, "burst2_valid");
        if (bstart.size() >= 2) checkOutput("period_500", 48'(bstart[1] - bstart[0]), 48'd500);

        $display("[TB] bursts 3-4: overrun");
        ft = 90;
        setBytes(48'h0080FF7F0180);
        pushBurst({16'h8000, 16'h7FFF, 16'h8001});
        pushBurst({16'h8000, 16'h7FFF, 16'h8001});
        waitUntil(W_VALID, 3, 1500, "burst3_valid");
        waitUntil(W_BSTART, 4, 50, "burst4_start");
        applyStimulus(1'b0, 1'b0, 1);
        if (bstart.size() >= 4 && vcyc.size() >= 3) begin
            checkOutput("period_before_overrun", 48'(bstart[2] - bstart[1]), 48'd500);
            checkOutput("overrun_restart", 48'(bstart[3] - vcyc[2]), 48'd1);
        end
        waitUntil(W_VALID, 4, 1000, "burst4_valid");
        applyStimulus(1'b0, 1'b0, 700);
        checkOutput("en_low_bursts", 48'(bstart.size()), 48'd4);
        checkOutput("en_low_valids", 48'(vcyc.size()), 48'd4);

        $display("[TB] burst 5: en rise with saturated timer");
        ft = 20;
        setBytes(48'h78562143EFBE);
        pushBurst({16'h5678, 16'h4321, 16'hBEEF});
        en_cyc = cyc + 1;
        applyStimulus(1'b0, 1'b1, 1);
        waitUntil(W_BSTART, 5, 20, "burst5_start");
        if (bstart.size() >= 5) checkOutput("en_rise_start", 48'(bstart[4] - en_cyc), 48'd1);
        waitUntil(W_VALID, 5, 600, "burst5_valid");
        applyStimulus(1'b0, 1'b0, 1);

        $display("[TB] reset while busy held");
`ifdef ACCEL_DEVID_CHECK_EN
        exp_tx.push_back(16'h8000);
`endif
        exp_tx.push_back(16'h310B);
        exp_tx.push_back(16'h2D08);
        n0 = scyc.size();
        hold_until = cyc + 31;
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("rst2_xyz", {ax, ay, az}, 48'd0);
        checkOutput("rst2_init_done", 48'(idn), 48'd0);
        applyStimulus(1'b0, 1'b0, 1);
        waitUntil(W_INIT, 1, 300, "init_done_after_hold");
        if (scyc.size() > n0) checkOutput("start_after_hold", 48'(scyc[n0] >= hold_until + 8), 48'd1);

        $display("[TB] handshake timeout and retry");
        respond = 1'b0;
        exp_tx.push_back(FIRST_TX);
        exp_tx.push_back(FIRST_TX);
        n0 = scyc.size();
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1);
        waitUntil(W_STARTS, n0 + 2, 100, "retry_start");
        checkOutput("timeout_seq_error", 48'(serr), 48'd1);
        if (scyc.size() >= n0 + 2) checkOutput("retry_spacing", 48'(scyc[n0 + 1] - scyc[n0]), 48'd5);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("rst_clears_error", 48'(serr), 48'd0);
        respond = 1'b1;

`ifdef ACCEL_DEVID_CHECK_EN
        $display("[TB] wrong DEVID");
        devid = 8'hE6;
        exp_tx.push_back(16'h8000);
        n0 = scyc.size();
        applyStimulus(1'b0, 1'b0, 200);
        checkOutput("devid_seq_error", 48'(serr), 48'd1);
        checkOutput("devid_init_done", 48'(idn), 48'd0);
        checkOutput("devid_starts", 48'(scyc.size() - n0), 48'd1);
`endif

        checkOutput("tx_queue_drained", 48'(exp_tx.size()), 48'd0);
        checkOutput("sample_queue_drained", 48'(exp_samp.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/accel_read_seq.md
Name: accel_read_seq

Overview:
- Command sequencer directly upstream of the 16-bit SPI master in the accelerometer SPI IP.
- After reset, writes two configuration registers to an ADXL345-style accelerometer. It then periodically burst-reads the six data registers (X0..Z1) and assembles signed 16-bit X/Y/Z samples.
- Drives the master's start/tx_data inputs and consumes its rx_data/busy outputs.
- Results go to the AXI register bank as a sample-valid pulse plus held sample registers.

Parameters:
- SAMPLE_PERIOD, 100000: clk cycles from one burst start to the next (min 1). At 100 MHz this gives 1 kHz.
- DATA_FORMAT_VAL, 8'h0B: value written to reg 0x31 (full-res, ±16 g).
- POWER_CTL_VAL, 8'h08: value written to reg 0x2D (measure mode).
- FRAME_GAP, 8: idle clk cycles enforced between consecutive SPI frames.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- en, in, 1: when high, periodic sampling runs. When low, the sequencer finishes the current burst and then idles.
- spi_start, out, 1: one-cycle start pulse to the SPI master.
- spi_tx_data, out, 16: frame to the SPI master. bit15 = R/W (1 = read), bit14 = MB = 0, bits13:8 = address, bits7:0 = write data (0x00 for reads).
- spi_rx_data, in, 16: frame from the SPI master. Read data is in bits 7:0.
- spi_busy, in, 1: SPI master busy. It rises the cycle after start is sampled and falls at frame end.
- accel_x, out, 16: signed X sample = {X1, X0}.
- accel_y, out, 16: signed Y sample = {Y1, Y0}.
- accel_z, out, 16: signed Z sample = {Z1, Z0}.
- sample_valid, out, 1: one-cycle pulse when all three sample registers have been updated together.
- init_done, out, 1: high once the configuration writes have completed.
- seq_error, out, 1: sticky error flag, cleared only by rst.

Behaviour:
- Reset values: spi_start = 0, spi_tx_data = 0, accel_x/y/z = 0, sample_valid = 0, init_done = 0, seq_error = 0. The FSM goes to WAIT_IDLE, the period timer is 0 and the frame index is 0.
- Reset during an operation:
  - The SPI master may still be mid-frame.
  - WAIT_IDLE holds until spi_busy = 0 for 1 cycle, then moves to GAP and then INIT.
  - No start is ever issued while spi_busy = 1.
- Frame handshake (shared by all frames):
  - ISSUE: drive spi_tx_data and pulse spi_start for exactly 1 cycle. spi_tx_data stays stable until the frame completes.
  - WAIT_RISE: wait for spi_busy = 1. If it has not risen within 4 cycles of the start pulse, set seq_error and return to ISSUE to retry the same frame.
  - WAIT_FALL: wait for spi_busy = 0, then latch spi_rx_data[7:0] into the byte buffer slot indexed by the frame index.
  - GAP: count FRAME_GAP cycles, then continue to the next frame or state.
- Init sequence: frame 0 = 16'h31xx with xx = DATA_FORMAT_VAL, then frame 1 = 16'h2Dxx with xx = POWER_CTL_VAL. init_done rises the cycle after the GAP that follows frame 1.
- IDLE: the period timer counts while init_done = 1. A burst starts when en = 1 and the timer has reached SAMPLE_PERIOD-1; the timer reloads to 0 at burst start.
- Burst: 6 read frames with tx = 16'h8000 | (addr << 8), addr 0x32 to 0x37 in order. Bytes go into buf[0..5].
- Burst completion:
  - accel_x = {buf1, buf0}, accel_y = {buf3, buf2}, accel_z = {buf5, buf4}. All three registers update in the same cycle, and sample_valid pulses in that same cycle.
  - Sample registers hold their value between bursts.
- Overrun: if the burst takes longer than SAMPLE_PERIOD, the timer saturates at SAMPLE_PERIOD-1. The next burst starts at the first IDLE cycle. Periods are never queued and sample_valid never pulses twice per burst.
- en falling mid-burst: the burst completes, sample_valid pulses, and the FSM stays in IDLE. On en rising, the first burst starts on the next cycle if the timer has saturated.
- Frame index is 3 bits and resets to 0 at the start of every burst.
- Steady-state latency from burst start to sample_valid is 6 × (1 + frame time + 1 + FRAME_GAP) cycles.

Optional Feature:
- Macro: ACCEL_DEVID_CHECK_EN.
- With the macro defined:
  - Before frame 0, issue a read of reg 0x00 (tx 16'h8000).
  - If rx[7:0] != 8'hE5, set seq_error, keep init_done = 0 and halt in a DEVID_FAIL state. Only rst leaves DEVID_FAIL.
  - If rx[7:0] == 8'hE5, proceed to init.
- Without the macro: no DEVID frame is issued and seq_error is set only by handshake timeouts.

Test Plan:
- Reset with the SPI model idle, busy latency 1 cycle, frame time 20 cycles:
  - Exactly two start pulses occur, with tx 16'h310B then 16'h2D08.
  - Start pulses are spaced ≥ FRAME_GAP cycles after busy falls.
  - init_done rises.
- SPI model returns bytes 34,12,CD,AB,00,80 for addresses 32..37 -> accel_x = 16'h1234, accel_y = 16'hABCD, accel_z = 16'h8000 (negative). One sample_valid pulse; tx addresses appear strictly in order 32..37.
- SAMPLE_PERIOD = 500 with a short frame time -> consecutive burst-start pulses are exactly 500 cycles apart.
- SAMPLE_PERIOD = 50 with a burst longer than 50 cycles -> the next burst starts the first cycle after the previous one ends, with no double sample_valid.
- rst asserted while the model holds busy = 1 for 30 more cycles -> no spi_start until busy falls, then the init sequence repeats.
- Model never raises busy -> seq_error = 1 after 4 cycles and the same tx_data is retried. With ACCEL_DEVID_CHECK_EN and DEVID 8'hE6: seq_error = 1, init_done stays 0, and no further starts are issued.
